// File: rtl/clk_period_monitor_pkg.sv
// Shared definitions for the slow-clock period monitor and other CDC blocks in the DAQ path.
package clk_period_monitor_pkg;

  localparam int unsigned DefaultSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitFirst = 2'd1,
    StMeasure   = 2'd2,
    StLost      = 2'd3
  } mon_state_e;

endpackage

// File: rtl/clk_period_monitor_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, with an edge-history flop and
// registered single-cycle rise/fall pulses.
module clk_period_monitor_sync_edge_detect
  import clk_period_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_pulse_q;
  logic                   fall_pulse_q;
  logic                   sync_out;
  logic                   fall;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;
  assign fall     = ~sync_out & hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      hist_q       <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q       <= sync_out;
      rise_pulse_q <= rise;
      fall_pulse_q <= fall;
    end
  end

  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous slow clock in clk cycles, hands each measurement
// over a single-entry valid/ready register and flags a lost clock through a watchdog.
module clk_period_monitor
  import clk_period_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned TIMEOUT     = 16000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] OneCnt     = CNT_W'(1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             locked_q, locked_d;
  logic             rise;
  logic             capture;

  clk_period_monitor_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (slow_clk),
    .rise       (rise),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    locked_d   = locked_q;
    capture    = 1'b0;

    if (!enable) begin
      state_d  = StIdle;
      cnt_d    = '0;
      valid_d  = 1'b0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StWaitFirst;
        end
        StWaitFirst: begin
          if (rise) begin
            cnt_d   = OneCnt;
            state_d = StMeasure;
          end else if (cnt_q == TimeoutCnt) begin
            state_d = StLost;
          end else begin
            cnt_d = cnt_q + OneCnt;
          end
        end
        StMeasure: begin
          // A rise in the timeout cycle still counts as a valid measurement.
          if (rise) begin
            capture  = 1'b1;
            cnt_d    = OneCnt;
            locked_d = 1'b1;
          end else if (cnt_q == TimeoutCnt) begin
            state_d  = StLost;
            locked_d = 1'b0;
          end else begin
            cnt_d = cnt_q + OneCnt;
          end
        end
        StLost: begin
          locked_d = 1'b0;
          if (rise) begin
            cnt_d   = OneCnt;
            state_d = StMeasure;
          end
        end
        default: state_d = StIdle;
      endcase

      // Single holding register: a concurrent accept frees the slot for the new capture.
      if (capture) begin
        if (!valid_q || period_ready) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (valid_q && period_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      locked_q   <= locked_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;
  assign locked       = locked_q;
  assign lost         = (state_q == StLost);

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench for clk_period_monitor against an event-timing reference model.
module tb_clk_period_monitor;

  localparam int CntW       = 8;
  localparam int Timeout    = 50;
  localparam int SyncStages = 2;

  logic            clk;
  logic            rst_n;
  logic            slow_clk;
  logic            enable;
  logic            rise_pulse;
  logic            fall_pulse;
  logic [CntW-1:0] period;
  logic            period_valid;
  logic            period_ready;
  logic            overflow;
  logic            locked;
  logic            lost;

  clk_period_monitor #(
    .CNT_W       (CntW),
    .SYNC_STAGES (SyncStages),
    .TIMEOUT     (Timeout)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slow_clk     (slow_clk),
    .enable       (enable),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overflow     (overflow),
    .locked       (locked),
    .lost         (lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: slow_clk sample history plus edge-index timing.
  bit [7:0] sh;
  int       edge_n = 0;
  bit       m_active, m_meas, m_lost, m_locked, m_valid, m_ovf, m_rise, m_fall;
  int       m_anchor, m_period;

  // Slow clock generator and stimulus controls.
  int gen_per = 0, gen_phase = 0, next_per = 0;
  bit rnd_per = 0, rnd_ready = 0;
  int rise_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sh = '0;
    m_active = 0; m_meas = 0; m_lost = 0; m_locked = 0;
    m_valid = 0; m_ovf = 0; m_rise = 0; m_fall = 0;
    m_anchor = 0; m_period = 0;
  endtask

  task automatic model_edge();
    bit rise_now, fall_now, cap;
    int meas;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // The synchronised level seen before this edge is the sample taken SyncStages edges ago.
    rise_now = sh[SyncStages-1] & ~sh[SyncStages];
    fall_now = ~sh[SyncStages-1] & sh[SyncStages];
    sh = {sh[6:0], slow_clk};
    m_rise = rise_now;
    m_fall = fall_now;
    m_ovf = 0;
    if (!enable) begin
      m_active = 0; m_valid = 0; m_locked = 0; m_lost = 0; m_meas = 0;
      return;
    end
    cap = 0;
    meas = 0;
    if (!m_active) begin
      m_active = 1;
      m_anchor = edge_n + 1;
      m_meas = 0;
      m_lost = 0;
    end else if (rise_now) begin
      if (m_meas && !m_lost) begin
        cap = 1;
        meas = edge_n - m_anchor;
      end
      m_anchor = edge_n;
      m_meas = 1;
      m_lost = 0;
    end else if (!m_lost && (edge_n - m_anchor == Timeout)) begin
      m_lost = 1;
      m_meas = 0;
      m_locked = 0;
    end
    if (cap) begin
      m_locked = 1;
      if (!m_valid || period_ready) begin
        m_period = meas;
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && period_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("rise_pulse",   32'(rise_pulse),   32'(m_rise));
    chk("fall_pulse",   32'(fall_pulse),   32'(m_fall));
    chk("period_valid", 32'(period_valid), 32'(m_valid));
    chk("period",       32'(period),       32'(m_period));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("locked",       32'(locked),       32'(m_locked));
    chk("lost",         32'(lost),         32'(m_lost));
  endtask

  task automatic drive_next();
    if (rnd_ready) period_ready = 1'($urandom_range(0, 1));
    if (gen_per == 0) begin
      gen_per = next_per;
      gen_phase = 0;
    end else begin
      gen_phase++;
      if (gen_phase >= gen_per) begin
        gen_phase = 0;
        gen_per = rnd_per ? int'($urandom_range(3, 60)) : next_per;
      end
    end
    slow_clk = (gen_per != 0) && (gen_phase < gen_per / 2);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (rise_pulse) rise_seen++;
      drive_next();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    period_ready = 1'b1;
    slow_clk = 1'b0;
    model_reset();
    step(3);
    #3 rst_n = 1'b1;
    step(2);

    // Steady 10-cycle slow clock with the consumer always ready.
    enable = 1'b1;
    next_per = 10;
    step(120);
    chk("steady_period", 32'(period), 32'd10);
    chk("steady_locked", 32'(locked), 32'd1);

    // Backpressure for three slow periods, then a single ready cycle.
    period_ready = 1'b0;
    step(30);
    chk("held_period", 32'(period), 32'd10);
    chk("held_valid", 32'(period_valid), 32'd1);
    period_ready = 1'b1;
    step(1);
    step(20);

    // Stop the slow clock low long enough to trip the watchdog, then restart.
    next_per = 0;
    step(70);
    chk("lost_after_stop", 32'(lost), 32'd1);
    chk("unlocked_after_stop", 32'(locked), 32'd0);
    next_per = 10;
    step(40);
    chk("restart_period", 32'(period), 32'd10);

    // Period changes mid-stream.
    next_per = 7;
    step(50);
    chk("period_7", 32'(period), 32'd7);
    next_per = 13;
    step(70);
    chk("period_13", 32'(period), 32'd13);

    // Randomised periods (some beyond the timeout) and random backpressure.
    rnd_per = 1'b1;
    rnd_ready = 1'b1;
    step(400);
    rnd_per = 1'b0;
    rnd_ready = 1'b0;
    period_ready = 1'b1;
    next_per = 10;
    step(60);

    // Disable while a measurement is pending.
    period_ready = 1'b0;
    for (int i = 0; i < 40 && !m_valid; i++) step(1);
    chk("valid_before_disable", 32'(period_valid), 32'd1);
    enable = 1'b0;
    rise_seen = 0;
    step(30);
    chk("disabled_valid", 32'(period_valid), 32'd0);
    chk("disabled_locked", 32'(locked), 32'd0);
    chk("pulses_while_disabled", 32'(rise_seen > 0), 32'd1);
    period_ready = 1'b1;
    enable = 1'b1;
    step(80);

    // Asynchronous reset in the middle of a measurement.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_valid", 32'(period_valid), 32'd0);
    step(3);
    #3 rst_n = 1'b1;
    step(60);
    chk("post_reset_period", 32'(period), 32'd10);

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
